// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM period/high-time capture block.
// Optional glitch filter is selected by PWM_CAPTURE_GLITCH_FILTER_EN (see pwm_edge_sync).
package pwm_capture_pkg;

  localparam int CNT_W_DEFAULT = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM pin and produces single-cycle rise/fall pulses.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-sample majority filter (+2 cycles latency).
module pwm_edge_sync (
  input  logic int_osc,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic lvl;

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;
  logic filt_q, filt_d;

  // A one-cycle pulse never occupies two of the three taps at once, so it is dropped.
  always_comb begin
    hist1_d = sync2_q;
    hist2_d = hist1_q;
    filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
  end

  always_ff @(posedge int_osc) begin
    if (rst) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      filt_q  <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    dly_d = lvl;
  end

  always_ff @(posedge int_osc) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign rise = lvl & ~dly_q;
  assign fall = ~lvl & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture: FSM and saturating measurement counter.
// Glitch filtering is enabled in pwm_edge_sync by defining PWM_CAPTURE_GLITCH_FILTER_EN.
//
// state | meaning
// IDLE  | waiting for a rise to arm a measurement
// HIGH  | pin high, counting high time
// LOW   | pin low, counting rest of period
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             int_osc,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  pwm_edge_sync u_edge_sync (
    .int_osc (int_osc),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_tmp_d    = hi_tmp_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH: begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) begin
              hi_tmp_d = cnt_q;
              state_d  = LOW;
            end
          end
        end
        LOW: begin
          // Saturation wins over a coincident rise so the counter never wraps into a result.
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_tmp_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = CNT_ONE;
            state_d     = HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge int_osc) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_tmp_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_tmp_q    <= hi_tmp_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule
